// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state type, owner codes and default sizes for mem_port_arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int MAX_D_BURST_DEF = 4;
    localparam int TIMEOUT_DEF     = 16;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// rtl/mem_arb_wdog.sv - busy-cycle watchdog for mem_port_arbiter, used when MEM_ARB_TIMEOUT_EN is defined
module mem_arb_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic ready,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter is zero in the first busy cycle because it is held clear while idle.
    always_comb begin
        cnt_d  = busy ? cnt_q + CNT_W'(1) : '0;
        expire = busy && !ready && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store; MEM_ARB_TIMEOUT_EN adds a busy watchdog
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_D_BURST = MAX_D_BURST_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic              stall,
    output logic              timeout_err
`else
    output logic              stall
`endif
);

    arb_state_e        state_q, state_d;
    logic [3:0]        dcnt_q, dcnt_d;
    logic              if_gnt_q, if_gnt_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_gnt_q, d_gnt_d;
    logic              d_valid_q, d_valid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              take_d, take_i, own, abort;

    always_comb begin
        // Data wins unless fetch has already waited out MAX_D_BURST data grants.
        take_d      = d_req && (!if_req || (dcnt_q < 4'(MAX_D_BURST)));
        take_i      = !take_d && if_req;
        own         = take_d ? OWN_D : OWN_I;
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        if_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_gnt_d     = 1'b0;
        d_valid_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (take_d || take_i) begin
                    state_d     = (own == OWN_D) ? BUSY_D : BUSY_I;
                    if_gnt_d    = take_i;
                    d_gnt_d     = take_d;
                    mem_req_d   = 1'b1;
                    mem_we_d    = take_d && d_we;
                    mem_addr_d  = take_d ? d_addr : if_addr;
                    mem_wdata_d = take_d ? d_wdata : '0;
                    dcnt_d      = take_d ? sat_inc4(dcnt_q) : 4'd0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready || abort) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_ready ? mem_rdata : '0;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = (mem_ready && !mem_we_q) ? mem_rdata : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!if_req) begin
            dcnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            dcnt_q      <= 4'd0;
            if_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_gnt_q     <= 1'b0;
            d_valid_q   <= 1'b0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            if_gnt_q    <= if_gnt_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_gnt_q     <= d_gnt_d;
            d_valid_q   <= d_valid_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic timeout_err_q, timeout_err_d;

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .busy   (state_q != IDLE),
        .ready  (mem_ready),
        .expire (abort)
    );

    assign timeout_err_d = abort;

    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    // Without the watchdog a busy access never aborts.
    assign abort = (TIMEOUT < 0);
`endif

    assign if_gnt    = if_gnt_q;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_valid   = d_valid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall     = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int MAX_D_BURST = 4;
    localparam int TIMEOUT     = 16;
    localparam int NV          = 22;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_valid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_D_BURST (MAX_D_BURST),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
`ifdef MEM_ARB_TIMEOUT_EN
        .stall       (stall),
        .timeout_err (timeout_err)
`else
        .stall     (stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rstn, ireq, iaddr, dreq, dwe, daddr, dwdata, rdy, rdata;
        logic [31:0] e_ignt, e_ival, e_irdata, e_dgnt, e_dval, e_drdata;
        logic [31:0] e_mreq, e_mwe, e_maddr, e_mwdata, e_stall;
    } vec_t;

    vec_t        tv[NV];
    int          n_tests = 0;
    int          n_fail  = 0;
    string       got_ord, exp_ord;
    int          igap, dgap, wcnt, ph, k, got_k;
    logic        saw_ignt, saw_dgnt;
    int          m_owner, m_dcnt;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, x_irdata, x_drdata;
    logic        x_ignt, x_dgnt, x_ival, x_dval, x_mreq, x_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1;
    endtask

    initial begin
        //          rstn ireq iaddr dreq dwe daddr   dwdata        rdy rdata         ignt ival irdata        dgnt dval drdata        mreq mwe maddr   mwdata        stall
        tv[0]  = '{0, 0, 0,     0, 0, 0,      0,            0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 0,      0,            0};
        tv[1]  = '{1, 1, 'h4,   0, 0, 0,      0,            1, 'h00500093,   0, 0, 0,            0, 0, 0,            0, 0, 0,      0,            1};
        tv[2]  = '{1, 1, 'h4,   0, 0, 0,      0,            1, 'h00500093,   1, 0, 0,            0, 0, 0,            1, 0, 'h4,    0,            1};
        tv[3]  = '{1, 0, 'h4,   0, 0, 0,      0,            1, 'h00500093,   0, 1, 'h00500093,   0, 0, 0,            0, 0, 0,      0,            0};
        tv[4]  = '{1, 0, 0,     1, 1, 'h100,  'hDEADBEEF,   0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 0,      0,            1};
        tv[5]  = '{1, 0, 0,     1, 1, 'h100,  'hDEADBEEF,   0, 0,            0, 0, 0,            1, 0, 0,            1, 1, 'h100,  'hDEADBEEF,   1};
        tv[6]  = '{1, 0, 0,     0, 0, 0,      0,            0, 0,            0, 0, 0,            0, 0, 0,            1, 1, 'h100,  'hDEADBEEF,   0};
        tv[7]  = '{1, 0, 0,     0, 0, 0,      0,            0, 0,            0, 0, 0,            0, 0, 0,            1, 1, 'h100,  'hDEADBEEF,   0};
        tv[8]  = '{1, 0, 0,     0, 0, 0,      0,            1, 'h12345678,   0, 0, 0,            0, 0, 0,            1, 1, 'h100,  'hDEADBEEF,   0};
        tv[9]  = '{1, 0, 0,     0, 0, 0,      0,            0, 0,            0, 0, 0,            0, 1, 0,            0, 0, 0,      0,            0};
        tv[10] = '{1, 1, 'h8,   1, 0, 'h200,  0,            1, 'hAAAA0001,   0, 0, 0,            0, 0, 0,            0, 0, 0,      0,            1};
        tv[11] = '{1, 1, 'h8,   1, 0, 'h200,  0,            1, 'hAAAA0001,   0, 0, 0,            1, 0, 0,            1, 0, 'h200,  0,            1};
        tv[12] = '{1, 1, 'h8,   0, 0, 0,      0,            1, 'hBBBB0002,   0, 0, 0,            0, 1, 'hAAAA0001,   0, 0, 0,      0,            1};
        tv[13] = '{1, 1, 'h8,   0, 0, 0,      0,            1, 'hBBBB0002,   1, 0, 0,            0, 0, 0,            1, 0, 'h8,    0,            1};
        tv[14] = '{1, 0, 0,     0, 0, 0,      0,            1, 0,            0, 1, 'hBBBB0002,   0, 0, 0,            0, 0, 0,      0,            0};
        tv[15] = '{1, 0, 0,     1, 0, 'h40,   0,            0, 0,            0, 0, 0,            0, 0, 0,            0, 0, 0,      0,            1};
        tv[16] = '{1, 0, 0,     1, 0, 'h40,   0,            0, 0,            0, 0, 0,            1, 0, 0,            1, 0, 'h40,   0,            1};
        tv[17] = '{0, 0, 0,     0, 0, 0,      0,            0, 0,            0, 0, 0,            0, 0, 0,            1, 0, 'h40,   0,            0};
        tv[18] = '{1, 0, 0,     0, 0, 0,      0,            1, 'h55,         0, 0, 0,            0, 0, 0,            0, 0, 0,      0,            0};
        tv[19] = '{1, 1, 0,     0, 0, 0,      0,            1, 'h13,         0, 0, 0,            0, 0, 0,            0, 0, 0,      0,            1};
        tv[20] = '{1, 1, 0,     0, 0, 0,      0,            1, 'h13,         1, 0, 0,            0, 0, 0,            1, 0, 0,      0,            1};
        tv[21] = '{1, 0, 0,     0, 0, 0,      0,            1, 'h13,         0, 1, 'h13,         0, 0, 0,            0, 0, 0,      0,            0};

        // Directed table: one row per clock cycle.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            rst = tv[i].rstn[0]; if_req = tv[i].ireq[0]; if_addr = tv[i].iaddr;
            d_req = tv[i].dreq[0]; d_we = tv[i].dwe[0]; d_addr = tv[i].daddr; d_wdata = tv[i].dwdata;
            mem_ready = tv[i].rdy[0]; mem_rdata = tv[i].rdata;
            #3;
            chk($sformatf("row%0d if_gnt", i), 32'(if_gnt), tv[i].e_ignt);
            chk($sformatf("row%0d d_gnt", i), 32'(d_gnt), tv[i].e_dgnt);
            chk($sformatf("row%0d if_valid", i), 32'(if_valid), tv[i].e_ival);
            chk($sformatf("row%0d d_valid", i), 32'(d_valid), tv[i].e_dval);
            chk($sformatf("row%0d mem_req", i), 32'(mem_req), tv[i].e_mreq);
            chk($sformatf("row%0d stall", i), 32'(stall), tv[i].e_stall);
            if (tv[i].e_ival[0]) chk($sformatf("row%0d if_rdata", i), if_rdata, tv[i].e_irdata);
            if (tv[i].e_dval[0]) chk($sformatf("row%0d d_rdata", i), d_rdata, tv[i].e_drdata);
            if (tv[i].e_mreq[0]) begin
                chk($sformatf("row%0d mem_addr", i), mem_addr, tv[i].e_maddr);
                chk($sformatf("row%0d mem_we", i), 32'(mem_we), tv[i].e_mwe);
                if (tv[i].e_mwe[0]) chk($sformatf("row%0d mem_wdata", i), mem_wdata, tv[i].e_mwdata);
            end
        end

        // Starvation: both requesters hold their request, zero-wait memory.
        do_reset();
        got_ord = "";
        exp_ord = "DDDDIDDDDI";
        for (int c = 0; c < 60 && got_ord.len() < 10; c++) begin
            @(posedge clk); #1;
            if_req = 1; if_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000;
            mem_ready = 1; mem_rdata = $urandom;
            #3;
            if (d_gnt) got_ord = {got_ord, "D"};
            if (if_gnt) got_ord = {got_ord, "I"};
        end
        chk("starve grant count", 32'(got_ord.len()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("starve grant %0d", i), (i < got_ord.len()) ? 32'(got_ord[i]) : 32'd0, 32'(exp_ord[i]));
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // Fetch to a memory that never answers.
        do_reset();
        ph = 0; k = 0; got_k = -1;
        for (int c = 0; c < 60 && got_k < 0; c++) begin
            @(posedge clk); #1;
            if_req = (ph == 0); if_addr = 32'h20; mem_ready = 0;
            #3;
            if (ph == 1) begin
                k++;
                if (if_valid) begin
                    got_k = k;
                    chk("timeout timeout_err", 32'(timeout_err), 32'd1);
                    chk("timeout if_rdata", if_rdata, 32'd0);
                end
            end
            if (ph == 0 && if_gnt) ph = 1;
        end
        chk("timeout latency", 32'(got_k), 32'(TIMEOUT));
`endif

        // Random traffic against a transaction-level reference.
        do_reset();
        igap = 0; dgap = 1; wcnt = 0; saw_ignt = 0; saw_dgnt = 0;
        m_owner = 0; m_dcnt = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        x_ignt = 0; x_dgnt = 0; x_ival = 0; x_dval = 0; x_mreq = 0; x_irdata = 0; x_drdata = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (if_req && saw_ignt) begin
                if ($urandom_range(1, 0) == 1) if_addr = $urandom & 32'hFFFF_FFFC;
                else begin if_req = 0; igap = $urandom_range(3, 0); end
            end else if (!if_req) begin
                if (igap == 0) begin if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC; end
                else igap--;
            end
            if (d_req && saw_dgnt) begin
                if ($urandom_range(1, 0) == 1) begin
                    d_we = 1'($urandom); d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
                end else begin d_req = 0; dgap = $urandom_range(3, 0); end
            end else if (!d_req) begin
                if (dgap == 0) begin
                    d_req = 1; d_we = 1'($urandom); d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
                end else dgap--;
            end
            mem_ready = (wcnt >= 5) || ($urandom_range(2, 0) != 0);
            if (mem_req && !mem_ready) wcnt++; else wcnt = 0;
            mem_rdata = $urandom;
            #3;
            x_stall = (if_req && !x_ival) || (d_req && !x_dval);
            chk("rnd if_gnt", 32'(if_gnt), 32'(x_ignt));
            chk("rnd d_gnt", 32'(d_gnt), 32'(x_dgnt));
            chk("rnd if_valid", 32'(if_valid), 32'(x_ival));
            chk("rnd d_valid", 32'(d_valid), 32'(x_dval));
            chk("rnd mem_req", 32'(mem_req), 32'(x_mreq));
            chk("rnd stall", 32'(stall), 32'(x_stall));
            if (x_ival) chk("rnd if_rdata", if_rdata, x_irdata);
            if (x_dval) chk("rnd d_rdata", d_rdata, x_drdata);
            if (x_mreq) begin
                chk("rnd mem_addr", mem_addr, m_addr);
                chk("rnd mem_we", 32'(mem_we), 32'(m_we));
                if (m_we) chk("rnd mem_wdata", mem_wdata, m_wdata);
            end
            saw_ignt = if_gnt;
            saw_dgnt = d_gnt;
            // Reference: one access at a time, data first unless fetch has waited MAX_D_BURST grants.
            x_ignt = 0; x_dgnt = 0; x_ival = 0; x_dval = 0;
            if (m_owner == 0) begin
                if (d_req && (!if_req || m_dcnt < MAX_D_BURST)) begin
                    m_owner = 2; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; x_dgnt = 1;
                    m_dcnt = (m_dcnt < 15) ? m_dcnt + 1 : 15;
                end else if (if_req) begin
                    m_owner = 1; m_we = 0; m_addr = if_addr; x_ignt = 1; m_dcnt = 0;
                end
            end else if (mem_ready) begin
                if (m_owner == 1) begin x_ival = 1; x_irdata = mem_rdata; end
                else begin x_dval = 1; x_drdata = m_we ? 32'd0 : mem_rdata; end
                m_owner = 0;
            end
            if (!if_req) m_dcnt = 0;
            x_mreq = (m_owner != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
